// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer controller: FSM states, 2-bit
// counter encodings, the table entry layout and the counter step helper.
package btb_pkg;

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int ENT_TAG_W = 8;
  localparam int ENT_PC_W  = 32;

  typedef struct packed {
    logic                 valid;
    logic [ENT_TAG_W-1:0] tag;
    logic [ENT_PC_W-1:0]  target;
    logic [1:0]           cnt;
  } btb_entry_t;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST) ? ST : c + 2'd1;
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous valid/ready FIFO with count-based full/empty, used to queue
// table write requests ahead of the single table write port.
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          push, pop;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rp];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB / 2-bit predictor table controller: initialises the table, serves the
// combinational fetch lookup and retires queued resolution writes one per cycle.
module btb_ctrl #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8,
  parameter int PC_W   = 32,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [1:0]       lk_cnt,
  output logic [PC_W-1:0]  lk_target,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_wrt,
  input  logic             upd_wrp,
  input  logic             upd_taken,
  input  logic [1:0]       upd_cnt,
  input  logic             tbl_clr,
  output logic             busy
);
  import btb_pkg::*;

  localparam int N  = 1 << IDX_W;
  localparam int PW = IDX_W + TAG_W + PC_W + 5;

  state_e           state;
  logic [IDX_W-1:0] ptr;

  logic [N-1:0]     tv;
  logic [TAG_W-1:0] ttag [N];
  logic [PC_W-1:0]  ttgt [N];
  logic [1:0]       tcnt [N];

  logic             run, q_in_ready, q_valid;
  logic [PW-1:0]    q_data;
  logic [IDX_W-1:0] q_idx;
  logic [TAG_W-1:0] q_tag;
  logic [PC_W-1:0]  q_target;
  logic             q_wrt, q_wrp, q_taken;
  logic [1:0]       q_cnt;

  assign run       = (state == RUN);
  assign upd_ready = run & q_in_ready;

  btb_upd_fifo #(.DEPTH(QDEPTH), .W(PW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (upd_valid & run),
    .in_ready  (q_in_ready),
    .in_data   ({upd_idx, upd_tag, upd_target, upd_wrt, upd_wrp, upd_taken, upd_cnt}),
    .out_valid (q_valid),
    .out_ready (1'b1),
    .out_data  (q_data)
  );

  assign {q_idx, q_tag, q_target, q_wrt, q_wrp, q_taken, q_cnt} = q_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (&ptr) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: if (tbl_clr) begin
          state <= DRAIN;
          busy  <= 1'b1;
        end
        // Each pop writes at its own edge, so an empty queue means nothing pending.
        DRAIN: if (!q_valid) begin
          state <= INIT;
          ptr   <= '0;
        end
        default: begin
          state <= INIT;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Queue is always empty in INIT, so sweep and pop writes never collide.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      tv[ptr]   <= 1'b0;
      ttag[ptr] <= '0;
      ttgt[ptr] <= '0;
      tcnt[ptr] <= WNT;
    end else if (q_valid) begin
      if (q_wrt) begin
        tv[q_idx]   <= 1'b1;
        ttag[q_idx] <= q_tag;
        ttgt[q_idx] <= q_target;
        tcnt[q_idx] <= q_taken ? WT : WNT;
      end else if (q_wrp) begin
        tcnt[q_idx] <= cnt_step(q_cnt, q_taken);
      end
    end
  end

  assign lk_hit    = (state != INIT) & tv[lk_idx] & (ttag[lk_idx] == lk_tag);
  assign lk_cnt    = tcnt[lk_idx];
  assign lk_target = ttgt[lk_idx];

endmodule
